// File: rtl/da_fir_serial_sequencer_pkg.sv
// Shared constants, FSM encoding and a counter-width helper for the DA FIR serial sequencer.
package da_fir_serial_sequencer_pkg;

  localparam int NB_DATA_IN   = 8;
  localparam int NB_DATA_OUT  = 28;
  localparam int N_TAPS       = 9;
  localparam int CORE_RST_CYC = 2;

  typedef enum logic [2:0] {
    ST_CORE_RST = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_HOLD     = 3'd4
  } seq_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/da_fir_serial_sequencer_p2s_shift.sv
// Parallel-load, LSB-first serialiser feeding the bit-serial DA FIR core.
module da_fir_serial_sequencer_p2s_shift
  import da_fir_serial_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [NB_DATA_IN-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_bit
);

  logic [NB_DATA_IN-1:0] sreg_q;
  logic [NB_DATA_IN-1:0] sreg_d;

  // Clear wins over load, load wins over shift; zeros fill from the top so the sign bit leaves last.
  always_comb begin
    sreg_d = sreg_q;
    if (i_clear) begin
      sreg_d = '0;
    end else if (i_load) begin
      sreg_d = i_data;
    end else if (i_shift) begin
      sreg_d = {1'b0, sreg_q[NB_DATA_IN-1:1]};
    end
  end

  // Shift register state.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign o_bit = sreg_q[0];

endmodule

// File: rtl/da_fir_serial_sequencer.sv
// Sequencer between a parallel sample stream and the bit-serial DA FIR core: frames the core enable,
// owns the core reset and buffers each core result behind a single-entry valid/ready output.
module da_fir_serial_sequencer
  import da_fir_serial_sequencer_pkg::*;
(
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [NB_DATA_IN-1:0]  i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [NB_DATA_OUT-1:0] o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_core_bit,
  output logic                   o_core_enable,
  output logic                   o_core_reset_n,
  input  logic [NB_DATA_OUT-1:0] i_core_data,
  output logic                   o_busy,
  output logic                   o_warm
);

  localparam int BIT_W = cnt_width(NB_DATA_IN);
  localparam int RST_W = cnt_width(CORE_RST_CYC);
  localparam int RES_W = cnt_width(N_TAPS + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_DATA_IN - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(CORE_RST_CYC - 1);
  localparam logic [RES_W-1:0] RES_MAX  = RES_W'(N_TAPS);

  seq_state_e             state_q, state_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [RES_W-1:0]       res_cnt_q, res_cnt_d;
  logic [NB_DATA_OUT-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;

  logic in_ready;
  logic core_enable;
  logic core_reset_n;
  logic busy;
  logic accept;
  logic buf_free;
  logic capture;
  logic p2s_bit;

  // The output buffer can take a new result if it is empty or being drained this very cycle.
  assign buf_free = !out_valid_q || i_out_ready;
  assign accept   = in_ready && i_in_valid;

  da_fir_serial_sequencer_p2s_shift u_p2s (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_load  (accept),
    .i_data  (i_in_data),
    .i_shift (state_q == ST_SHIFT),
    .o_bit   (p2s_bit)
  );

  // FSM state register; reset lands in CORE_RST so the core is always re-initialised.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_CORE_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CORE_RST: if (rst_cnt_q == RST_LAST) state_d = ST_IDLE;
      ST_IDLE:     if (accept) state_d = ST_SHIFT;
      ST_SHIFT:    if (bit_cnt_q == BIT_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE:  begin
        if (buf_free) begin
          state_d = accept ? ST_SHIFT : ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:     if (i_out_ready) state_d = ST_IDLE;
      default:     state_d = ST_CORE_RST;
    endcase
    if (i_flush) begin
      state_d = ST_CORE_RST;
    end
  end

  // Moore-style outputs from the state, with in_ready refused during a flush cycle.
  always_comb begin
    in_ready     = 1'b0;
    core_enable  = 1'b0;
    core_reset_n = 1'b1;
    busy         = 1'b1;
    unique case (state_q)
      ST_CORE_RST: core_reset_n = 1'b0;
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SHIFT:    core_enable = 1'b1;
      ST_CAPTURE:  in_ready = buf_free;
      ST_HOLD:     in_ready = 1'b0;
      default:     core_reset_n = 1'b0;
    endcase
    if (i_flush) begin
      in_ready = 1'b0;
    end
  end

  // Counters and output buffer: drain on handshake, capture the core result, saturate the result count.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    res_cnt_d   = res_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    capture     = 1'b0;
    if (out_valid_q && i_out_ready) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_CORE_RST: rst_cnt_d = (rst_cnt_q == RST_LAST) ? '0 : rst_cnt_q + RST_W'(1);
      ST_IDLE:     if (accept) bit_cnt_d = '0;
      ST_SHIFT:    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      ST_CAPTURE: begin
        capture = buf_free;
        if (accept) bit_cnt_d = '0;
      end
      ST_HOLD:     capture = i_out_ready;
      default:     rst_cnt_d = '0;
    endcase
    if (capture) begin
      out_data_d  = i_core_data;
      out_valid_d = 1'b1;
      if (res_cnt_q != RES_MAX) begin
        res_cnt_d = res_cnt_q + RES_W'(1);
      end
    end
    if (i_flush) begin
      rst_cnt_d   = '0;
      bit_cnt_d   = '0;
      res_cnt_d   = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end
  end

  // Counter and output buffer registers.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      rst_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      res_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      res_cnt_q   <= res_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_in_ready     = in_ready;
  assign o_core_enable  = core_enable;
  assign o_core_reset_n = core_reset_n;
  assign o_core_bit     = core_enable & p2s_bit;
  assign o_busy         = busy;
  assign o_out_data     = out_data_q;
  assign o_out_valid    = out_valid_q;
  assign o_warm         = (res_cnt_q == RES_MAX);

endmodule

// File: tb/tb_da_fir_serial_sequencer.sv
// Directed bench for the DA FIR serial sequencer, with a behavioural 9-tap bit-serial core attached.
`timescale 1ns/1ps
module tb_da_fir_serial_sequencer;

   logic        clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_flush;
   logic [7:0]  i_in_data;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [27:0] o_out_data;
   logic        o_out_valid;
   logic        i_out_ready;
   logic        o_core_bit;
   logic        o_core_enable;
   logic        o_core_reset_n;
   logic [27:0] i_core_data;
   logic        o_busy;
   logic        o_warm;

   int checks = 0;
   int errors = 0;

   // Core coefficients (Q15) and the hand-computed impulse response for an 8'h40 (0.5) input.
   localparam int H [0:8]   = '{100, -200, 300, 400, 500, 400, 300, -200, 100};
   localparam int IMP [0:8] = '{6400, -12800, 19200, 25600, 32000, 25600, 19200, -12800, 6400};

   always #5 clock = ~clock;

   da_fir_serial_sequencer dut (
      .clock          (clock),
      .i_reset        (i_reset),
      .i_flush        (i_flush),
      .i_in_data      (i_in_data),
      .i_in_valid     (i_in_valid),
      .o_in_ready     (o_in_ready),
      .o_out_data     (o_out_data),
      .o_out_valid    (o_out_valid),
      .i_out_ready    (i_out_ready),
      .o_core_bit     (o_core_bit),
      .o_core_enable  (o_core_enable),
      .o_core_reset_n (o_core_reset_n),
      .i_core_data    (i_core_data),
      .o_busy         (o_busy),
      .o_warm         (o_warm)
   );

   // Behavioural DA FIR core: gathers LSB-first bits, on the 8th enabled bit runs the FIR and updates its output.
   logic [7:0] coreSreg;
   int         coreCnt;
   int         dline [0:7];
   always @(posedge clock) begin : core_model
      logic [7:0] frame;
      int acc;
      if (!o_core_reset_n) begin
         coreSreg    <= '0;
         coreCnt     <= 0;
         i_core_data <= '0;
         for (int k = 0; k < 8; k++) dline[k] <= 0;
      end else if (o_core_enable) begin
         frame = {o_core_bit, coreSreg[7:1]};
         coreSreg <= frame;
         if (coreCnt == 7) begin
            coreCnt <= 0;
            acc = H[0] * int'($signed(frame));
            for (int k = 1; k < 9; k++) acc += H[k] * dline[k-1];
            for (int k = 7; k > 0; k--) dline[k] <= dline[k-1];
            dline[0]    <= int'($signed(frame));
            i_core_data <= acc[27:0];
         end else begin
            coreCnt <= coreCnt + 1;
         end
      end
   end

   // Watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Wait (bounded) for in_ready, offer one sample for one cycle; returns at the negedge after the accept.
   task automatic applyStimulus(input logic [7:0] d);
      int n = 0;
      while (!o_in_ready && n < 60) begin
         tick();
         n++;
      end
      if (!o_in_ready) begin
         checkOutput("accept_timeout", o_in_ready, 1);
         return;
      end
      i_in_data  = d;
      i_in_valid = 1'b1;
      tick();
      i_in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid and return the presented result.
   task automatic waitResult(output logic signed [31:0] d);
      int n = 0;
      while (!o_out_valid && n < 40) begin
         tick();
         n++;
      end
      checkOutput("result_timeout", o_out_valid, 1);
      d = $signed(o_out_data);
   endtask

   initial begin
      logic signed [31:0] res;
      logic [7:0] bits;
      int enCnt;
      int accCyc [0:19];
      int acc, resCnt, enLow, gapBad, stableBad;

      i_flush     = 1'b0;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      i_out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      checkOutput("rst_core_reset_n", o_core_reset_n, 0);
      checkOutput("rst_busy", o_busy, 1);
      checkOutput("rst_in_ready", o_in_ready, 0);
      checkOutput("rst_out_valid", o_out_valid, 0);
      checkOutput("rst_core_enable", o_core_enable, 0);
      checkOutput("rst_warm", o_warm, 0);

      // Reset release: core reset held low exactly two cycles
      i_reset = 1'b0;
      tick();
      checkOutput("rel_core_reset_n_c1", o_core_reset_n, 0);
      checkOutput("rel_in_ready_c1", o_in_ready, 0);
      tick();
      checkOutput("rel_core_reset_n_c2", o_core_reset_n, 1);
      checkOutput("rel_in_ready_c2", o_in_ready, 1);
      checkOutput("rel_busy_c2", o_busy, 0);

      // Serialisation of 8'hA5, LSB first, then latency and first result
      applyStimulus(8'hA5);
      bits  = '0;
      enCnt = 0;
      for (int i = 0; i < 8; i++) begin
         bits[i] = o_core_bit;
         enCnt += int'(o_core_enable);
         tick();
      end
      checkOutput("ser_bits", bits, 8'hA5);
      checkOutput("ser_enable_cycles", enCnt, 8);
      checkOutput("capture_enable", o_core_enable, 0);
      checkOutput("capture_out_valid", o_out_valid, 0);
      checkOutput("capture_in_ready", o_in_ready, 1);
      tick();
      checkOutput("latency_out_valid", o_out_valid, 1);
      checkOutput("a5_result", $signed(o_out_data), -9100);
      tick();
      checkOutput("a5_drained", o_out_valid, 0);

      // Flush in IDLE with a sample offered: not accepted, core reset re-run
      i_in_data  = 8'h7F;
      i_in_valid = 1'b1;
      i_flush    = 1'b1;
      #1;
      checkOutput("flush_in_ready", o_in_ready, 0);
      tick();
      i_flush    = 1'b0;
      i_in_valid = 1'b0;
      checkOutput("flush_core_reset_n_c1", o_core_reset_n, 0);
      checkOutput("flush_no_accept", o_core_enable, 0);
      tick();
      checkOutput("flush_core_reset_n_c2", o_core_reset_n, 0);
      tick();
      checkOutput("flush_core_reset_n_c3", o_core_reset_n, 1);

      // Impulse response: 8'h40 then eight zeros, warm rises with the ninth result
      for (int k = 0; k < 9; k++) begin
         applyStimulus((k == 0) ? 8'h40 : 8'h00);
         waitResult(res);
         checkOutput($sformatf("impulse_%0d", k), res, IMP[k]);
         checkOutput($sformatf("warm_%0d", k), o_warm, (k == 8) ? 1 : 0);
      end

      // Back-to-back: valid held for 20 samples
      acc    = 0;
      resCnt = 0;
      enLow  = 0;
      gapBad = 0;
      i_in_data  = 8'h00;
      i_in_valid = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (acc > 0 && acc < 20 && !o_core_enable) enLow++;
         if (acc > 0 && o_out_valid && i_out_ready) resCnt++;
         if (o_in_ready && i_in_valid) begin
            accCyc[acc] = cyc;
            acc++;
         end
         tick();
         i_in_data = i_in_data + 8'd3;
         if (acc == 20) i_in_valid = 1'b0;
      end
      for (int i = 1; i < 20; i++) begin
         if (accCyc[i] - accCyc[i-1] != 9) gapBad++;
      end
      checkOutput("b2b_accepts", acc, 20);
      checkOutput("b2b_gaps", gapBad, 0);
      checkOutput("b2b_enable_low", enLow, 19);
      checkOutput("b2b_results", resCnt, 20);

      // Flush mid-SHIFT (bit_cnt=4) with the output buffer full
      checkOutput("pre_flush_warm", o_warm, 1);
      i_out_ready = 1'b0;
      applyStimulus(8'h11);
      waitResult(res);
      applyStimulus(8'h22);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("midshift_enable", o_core_enable, 1);
      checkOutput("midshift_out_valid", o_out_valid, 1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      checkOutput("mflush_out_valid", o_out_valid, 0);
      checkOutput("mflush_warm", o_warm, 0);
      checkOutput("mflush_core_reset_n_c1", o_core_reset_n, 0);
      checkOutput("mflush_enable", o_core_enable, 0);
      tick();
      checkOutput("mflush_core_reset_n_c2", o_core_reset_n, 0);
      tick();
      checkOutput("mflush_core_reset_n_c3", o_core_reset_n, 1);
      i_out_ready = 1'b1;
      applyStimulus(8'hC0);
      waitResult(res);
      checkOutput("mflush_fresh_result", res, -6400);

      // Backpressure: second result waits in HOLD, then both delivered in order
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_out_ready = 1'b0;
      applyStimulus(8'h10);
      waitResult(res);
      checkOutput("bp_first_value", res, 1600);
      applyStimulus(8'h08);
      stableBad = 0;
      for (int i = 0; i < 25; i++) begin
         if (!o_out_valid || $signed(o_out_data) != 1600) stableBad++;
         tick();
      end
      checkOutput("bp_stable", stableBad, 0);
      checkOutput("bp_hold_in_ready", o_in_ready, 0);
      checkOutput("bp_hold_busy", o_busy, 1);
      checkOutput("bp_hold_enable", o_core_enable, 0);
      i_out_ready = 1'b1;
      checkOutput("bp_drain_first", $signed(o_out_data), 1600);
      tick();
      checkOutput("bp_second_valid", o_out_valid, 1);
      checkOutput("bp_second_value", $signed(o_out_data), -2400);
      tick();
      checkOutput("bp_final_empty", o_out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
